// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and
// a 3-input majority helper used by the receiver's glitch filter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int TICKS_PER_BIT = 8;
  localparam int DATA_BITS     = 8;
  localparam int START_MID     = 3;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input.
// Both flops reset high so an idle-high line never glitches low.
module uart_sync2
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver sampling on an 8x tick at mid-bit.
// Define UART_RX_MAJORITY_EN for a 3-sample majority glitch filter.
module uart_rx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_8x,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [2:0] S_MID  = 3'(START_MID);
  localparam logic [2:0] S_LAST = 3'(TICKS_PER_BIT - 1);
  localparam logic [2:0] N_LAST = 3'(DATA_BITS - 1);

  state_t     state;
  logic [2:0] s;
  logic [2:0] n;
  logic [7:0] shreg;
  logic       armed;
  logic       rx_s;
  logic       b;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_serial),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Two stored samples plus the current one form the 3-sample window.
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 2'b11;
    end else if (tick_8x) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign b = maj3({hist, rx_s});
`else
  assign b = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s         <= 3'd0;
      n         <= 3'd0;
      shreg     <= 8'h00;
      armed     <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (tick_8x) begin
        unique case (state)
          IDLE: begin
            if (armed && !b) begin
              state <= START;
              s     <= 3'd0;
              armed <= 1'b0;
              busy  <= 1'b1;
            end else if (b) begin
              armed <= 1'b1;
            end
          end
          START: begin
            if (s != S_MID) begin
              s <= s + 3'd1;
            end else if (!b) begin
              state <= DATA;
              s     <= 3'd0;
              n     <= 3'd0;
            end else begin
              state <= IDLE;
              s     <= 3'd0;
              busy  <= 1'b0;
            end
          end
          DATA: begin
            if (s != S_LAST) begin
              s <= s + 3'd1;
            end else begin
              shreg <= {b, shreg[7:1]};
              s     <= 3'd0;
              if (n == N_LAST) state <= STOP;
              else             n <= n + 3'd1;
            end
          end
          STOP: begin
            if (s != S_LAST) begin
              s <= s + 3'd1;
            end else begin
              rx_data   <= shreg;
              rx_valid  <= b;
              frame_err <= !b;
              state     <= IDLE;
              s         <= 3'd0;
              busy      <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a tick every 4 clk.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_serial = 1'b1;
  logic [1:0] tdiv = 2'd0;
  logic       tick_8x;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int vcnt = 0;
  int fcnt = 0;
  logic       prev_pulse = 1'b0;
  logic [7:0] got[$];

  uart_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_8x   (tick_8x),
    .rx_serial (rx_serial),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tdiv <= tdiv + 2'd1;
  assign tick_8x = (tdiv == 2'd3);

  always @(negedge clk) begin
    if (rx_valid) begin
      vcnt++;
      got.push_back(rx_data);
    end
    if (frame_err) fcnt++;
    if (rx_valid || frame_err) begin
      checks++;
      if ((rx_valid && frame_err) || prev_pulse) begin
        failures++;
        $display("FAIL pulse_excl valid=%b ferr=%b prev=%b req=exclusive",
                 rx_valid, frame_err, prev_pulse);
      end
    end
    prev_pulse = rx_valid || frame_err;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog time limit expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  task automatic next_tick();
    @(negedge clk);
    while (tdiv != 2'd0) @(negedge clk);
  endtask

  task automatic ticks(input int k);
    repeat (k) next_tick();
  endtask

  task automatic send_bit(input logic v);
    rx_serial = v;
    ticks(8);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_data !== 8'h00) begin
      failures++;
      $display("FAIL rst_data got=%h req=00", rx_data);
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_valid got=%b req=0", rx_valid);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_ferr got=%b req=0", frame_err);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy got=%b req=0", busy);
    end
    next_tick();
    rst_n = 1'b1;
    ticks(4);
  endtask

  task automatic test_good_frame();
    int v0 = vcnt;
    int f0 = fcnt;
    send_byte(8'hA5, 1'b1);
    ticks(4);
    checks++;
    if (vcnt - v0 !== 1) begin
      failures++;
      $display("FAIL good_valid_cnt got=%0d req=1", vcnt - v0);
    end
    checks++;
    if (fcnt - f0 !== 0) begin
      failures++;
      $display("FAIL good_ferr_cnt got=%0d req=0", fcnt - f0);
    end
    checks++;
    if (rx_data !== 8'hA5) begin
      failures++;
      $display("FAIL good_data got=%h req=a5", rx_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL good_busy got=%b req=0", busy);
    end
  endtask

  task automatic test_bad_stop();
    int v0 = vcnt;
    int f0 = fcnt;
    send_byte(8'h3C, 1'b0);
    ticks(200);
    checks++;
    if (fcnt - f0 !== 1) begin
      failures++;
      $display("FAIL bad_ferr_cnt got=%0d req=1", fcnt - f0);
    end
    checks++;
    if (vcnt - v0 !== 0) begin
      failures++;
      $display("FAIL bad_valid_cnt got=%0d req=0", vcnt - v0);
    end
    checks++;
    if (rx_data !== 8'h3C) begin
      failures++;
      $display("FAIL bad_data got=%h req=3c", rx_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL break_busy got=%b req=0", busy);
    end
    rx_serial = 1'b1;
    ticks(16);
    checks++;
    if (vcnt - v0 + fcnt - f0 !== 1) begin
      failures++;
      $display("FAIL break_pulses got=%0d req=1",
               vcnt - v0 + fcnt - f0);
    end
  endtask

  task automatic test_false_start();
    int v0 = vcnt;
    int f0 = fcnt;
    rx_serial = 1'b0;
    ticks(2);
    rx_serial = 1'b1;
    ticks(2);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL fs_busy_hi got=%b req=1", busy);
    end
    ticks(2);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL fs_busy_lo got=%b req=0", busy);
    end
    ticks(16);
    checks++;
    if (vcnt - v0 + fcnt - f0 !== 0) begin
      failures++;
      $display("FAIL fs_pulses got=%0d req=0", vcnt - v0 + fcnt - f0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    int v0 = vcnt;
    int f0 = fcnt;
    int g0 = got.size();
    exp[0] = 8'h00;
    exp[1] = 8'hFF;
    exp[2] = 8'h55;
    for (int i = 0; i < 3; i++) send_byte(exp[i], 1'b1);
    ticks(4);
    checks++;
    if (vcnt - v0 !== 3) begin
      failures++;
      $display("FAIL b2b_valid_cnt got=%0d req=3", vcnt - v0);
    end
    checks++;
    if (fcnt - f0 !== 0) begin
      failures++;
      $display("FAIL b2b_ferr_cnt got=%0d req=0", fcnt - f0);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got.size() <= g0 + i) begin
        failures++;
        $display("FAIL b2b_data%0d got=none req=%h", i, exp[i]);
      end else if (got[g0 + i] !== exp[i]) begin
        failures++;
        $display("FAIL b2b_data%0d got=%h req=%h",
                 i, got[g0 + i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int v0 = vcnt;
    int f0 = fcnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx_serial = 1'b1;
    ticks(4);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rx_data !== 8'h00) begin
      failures++;
      $display("FAIL mid_rst busy=%b data=%h req=0/00", busy, rx_data);
    end
    checks++;
    if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_pulse v=%b f=%b req=0/0",
               rx_valid, frame_err);
    end
    ticks(2);
    rst_n = 1'b1;
    ticks(4);
    send_byte(8'h81, 1'b1);
    ticks(4);
    checks++;
    if (vcnt - v0 !== 1 || fcnt - f0 !== 0) begin
      failures++;
      $display("FAIL mid_after_cnt v=%0d f=%0d req=1/0",
               vcnt - v0, fcnt - f0);
    end
    checks++;
    if (rx_data !== 8'h81) begin
      failures++;
      $display("FAIL mid_after_data got=%h req=81", rx_data);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] exp;
    int v0 = vcnt;
`ifdef UART_RX_MAJORITY_EN
    exp = 8'h00;
`else
    exp = 8'h04;
`endif
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    rx_serial = 1'b0;
    ticks(4);
    rx_serial = 1'b1;
    ticks(1);
    rx_serial = 1'b0;
    ticks(3);
    for (int i = 3; i < 8; i++) send_bit(1'b0);
    send_bit(1'b1);
    ticks(4);
    checks++;
    if (vcnt - v0 !== 1) begin
      failures++;
      $display("FAIL glitch_cnt got=%0d req=1", vcnt - v0);
    end
    checks++;
    if (rx_data !== exp) begin
      failures++;
      $display("FAIL glitch_data got=%h req=%h", rx_data, exp);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_stop();
    test_false_start();
    test_back_to_back();
    test_reset_mid();
    test_glitch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
